// File: rtl/pma_cfg_ctrl_pkg.sv
// Shared types and constants for the PMA region-table configuration controller.
// Every design file imports this package.
package pma_cfg_ctrl_pkg;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
        logic        lock;
        logic        idempotent;
        logic        read_only;
        logic        executable;
    } pma_cfg_t;

    localparam logic [1:0] PMA_FIELD_BASE = 2'd0;
    localparam logic [1:0] PMA_FIELD_MASK = 2'd1;
    localparam logic [1:0] PMA_FIELD_ATTR = 2'd2;

    localparam int PMA_ATTR_EXEC = 0;
    localparam int PMA_ATTR_RO   = 1;
    localparam int PMA_ATTR_IDEM = 2;
    localparam int PMA_ATTR_LOCK = 7;

    localparam pma_cfg_t PMA_DEFAULT = '{
        base: 32'h0000_0000, mask: 32'h0000_0000,
        lock: 1'b0, idempotent: 1'b1, read_only: 1'b0, executable: 1'b1
    };

    typedef enum logic [1:0] {
        PMA_IDLE,
        PMA_COMMIT,
        PMA_REPAIR
    } pma_ctrl_state_t;

    // Even parity over the significant base/mask bits and the four attribute bits.
    function automatic logic pma_parity(input pma_cfg_t c, input int align);
        logic [31:0] keep;
        keep = 32'hFFFF_FFFF << align;
        return (^(c.base & keep)) ^ (^(c.mask & keep)) ^
               c.lock ^ c.idempotent ^ c.read_only ^ c.executable;
    endfunction

    function automatic logic [31:0] pma_attr_word(input pma_cfg_t c);
        return {24'd0, c.lock, 4'd0, c.idempotent, c.read_only, c.executable};
    endfunction

endpackage

// File: rtl/pma_cfg_ctrl_region.sv
// One region of the PMA table: storage, field update, reload to default,
// and a stored parity bit with continuous mismatch detection.
module pma_region_reg
    import pma_cfg_ctrl_pkg::*;
#(
    parameter int       PMA_ALIGN = 10,
    parameter pma_cfg_t RESET_CFG = PMA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_field,
    input  logic [31:0] wr_data,
    input  logic        reload_en,
    input  logic        inj_en,
    output pma_cfg_t    cfg,
    output logic        par_err
);

    localparam logic [31:0] KEEP = 32'hFFFF_FFFF << PMA_ALIGN;
    localparam pma_cfg_t CLEAN_CFG = '{
        base: RESET_CFG.base, mask: RESET_CFG.mask, lock: 1'b0,
        idempotent: RESET_CFG.idempotent, read_only: RESET_CFG.read_only,
        executable: RESET_CFG.executable
    };

    pma_cfg_t cfg_reg, cfg_next;
    logic     par_reg, par_next;

    always_comb begin
        cfg_next = cfg_reg;
        if (reload_en) begin
            cfg_next = CLEAN_CFG;
        end else if (wr_en) begin
            case (wr_field)
                PMA_FIELD_BASE: cfg_next.base = wr_data & KEEP;
                PMA_FIELD_MASK: cfg_next.mask = wr_data & KEEP;
                PMA_FIELD_ATTR: begin
                    cfg_next.executable = wr_data[PMA_ATTR_EXEC];
                    cfg_next.read_only  = wr_data[PMA_ATTR_RO];
                    cfg_next.idempotent = wr_data[PMA_ATTR_IDEM];
                    cfg_next.lock       = cfg_reg.lock | wr_data[PMA_ATTR_LOCK];
                end
                default: ;
            endcase
        end
        // Injection lands after any recompute so a same-cycle update still ends corrupted.
        par_next = ((reload_en || wr_en) ? pma_parity(cfg_next, PMA_ALIGN) : par_reg) ^ inj_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg <= CLEAN_CFG;
            par_reg <= pma_parity(CLEAN_CFG, PMA_ALIGN);
        end else begin
            cfg_reg <= cfg_next;
            par_reg <= par_next;
        end
    end

    assign cfg     = cfg_reg;
    assign par_err = pma_parity(cfg_reg, PMA_ALIGN) ^ par_reg;

endmodule

// File: rtl/pma_cfg_ctrl.sv
// Run-time controller for the PMA region table: accepts guarded writes over a
// valid/ready port and scrubs regions in the background, repairing parity faults.
module pma_cfg_ctrl
    import pma_cfg_ctrl_pkg::*;
#(
    parameter int                          PMA_REGIONS = 4,
    parameter int                          PMA_ALIGN   = 10,
    parameter pma_cfg_t [PMA_REGIONS-1:0]  PMA_CFG     = {PMA_REGIONS{PMA_DEFAULT}},
    localparam int                         RW          = (PMA_REGIONS > 1) ? $clog2(PMA_REGIONS) : 1
) (
    input  logic                          s_clk_i,
    input  logic                          s_resetn_i,
    input  logic                          s_wr_valid_i,
    output logic                          s_wr_ready_o,
    input  logic [RW-1:0]                 s_wr_index_i,
    input  logic [1:0]                    s_wr_field_i,
    input  logic [31:0]                   s_wr_data_i,
    output logic                          s_wr_err_o,
    input  logic [RW-1:0]                 s_rd_index_i,
    input  logic [1:0]                    s_rd_field_i,
    output logic [31:0]                   s_rd_data_o,
    output pma_cfg_t [PMA_REGIONS-1:0]    s_cfg_o,
    output logic [PMA_REGIONS-1:0]        s_lock_o,
    input  logic                          s_inj_valid_i,
    input  logic [RW-1:0]                 s_inj_index_i,
    output logic                          s_scrub_err_o,
    output logic [7:0]                    s_scrub_cnt_o
);

    pma_ctrl_state_t             state_reg;
    logic [RW-1:0]               idx_reg, ptr_reg, ptr_next;
    logic [1:0]                  field_reg;
    logic [31:0]                 data_reg;
    logic                        wr_ready_reg, wr_err_reg, scrub_err_reg;
    logic [7:0]                  scrub_cnt_reg;

    pma_cfg_t [PMA_REGIONS-1:0]  cfg;
    logic [PMA_REGIONS-1:0]      par_err, hs_dec, ptr_dec, wr_en, reload_en, inj_en;
    logic                        hs_reject, scrub_bad;

    genvar gi;
    generate
        for (gi = 0; gi < PMA_REGIONS; gi++) begin : g_region
            assign hs_dec[gi]    = (s_wr_index_i == RW'(gi));
            assign ptr_dec[gi]   = (ptr_reg == RW'(gi));
            assign wr_en[gi]     = (state_reg == PMA_COMMIT) && !wr_err_reg && (idx_reg == RW'(gi));
            assign reload_en[gi] = (state_reg == PMA_REPAIR) && ptr_dec[gi];
            assign inj_en[gi]    = s_inj_valid_i && (s_inj_index_i == RW'(gi));
            assign s_lock_o[gi]  = cfg[gi].lock;

            pma_region_reg #(
                .PMA_ALIGN (PMA_ALIGN),
                .RESET_CFG (PMA_CFG[gi])
            ) u_region (
                .clk       (s_clk_i),
                .rst_n     (s_resetn_i),
                .wr_en     (wr_en[gi]),
                .wr_field  (field_reg),
                .wr_data   (data_reg),
                .reload_en (reload_en[gi]),
                .inj_en    (inj_en[gi]),
                .cfg       (cfg[gi]),
                .par_err   (par_err[gi])
            );
        end
    endgenerate

    // Lock cannot change between handshake and COMMIT, so the verdict is taken at handshake.
    assign hs_reject = !(|hs_dec) || (s_wr_field_i == 2'd3) || (|(hs_dec & s_lock_o));
    assign scrub_bad = |(par_err & ptr_dec);
    assign ptr_next  = (ptr_reg == RW'(PMA_REGIONS - 1)) ? '0 : ptr_reg + RW'(1);

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_reg     <= PMA_IDLE;
            idx_reg       <= '0;
            field_reg     <= '0;
            data_reg      <= '0;
            ptr_reg       <= '0;
            wr_ready_reg  <= 1'b1;
            wr_err_reg    <= 1'b0;
            scrub_err_reg <= 1'b0;
            scrub_cnt_reg <= '0;
        end else begin
            case (state_reg)
                PMA_IDLE: begin
                    if (s_wr_valid_i) begin
                        idx_reg      <= s_wr_index_i;
                        field_reg    <= s_wr_field_i;
                        data_reg     <= s_wr_data_i;
                        wr_err_reg   <= hs_reject;
                        wr_ready_reg <= 1'b0;
                        state_reg    <= PMA_COMMIT;
                    end else if (scrub_bad) begin
                        scrub_err_reg <= 1'b1;
                        wr_ready_reg  <= 1'b0;
                        state_reg     <= PMA_REPAIR;
                    end else begin
                        ptr_reg <= ptr_next;
                    end
                end
                PMA_COMMIT: begin
                    wr_err_reg   <= 1'b0;
                    wr_ready_reg <= 1'b1;
                    state_reg    <= PMA_IDLE;
                end
                PMA_REPAIR: begin
                    scrub_err_reg <= 1'b0;
                    if (scrub_cnt_reg != 8'hFF) begin
                        scrub_cnt_reg <= scrub_cnt_reg + 8'd1;
                    end
                    ptr_reg      <= ptr_next;
                    wr_ready_reg <= 1'b1;
                    state_reg    <= PMA_IDLE;
                end
                default: begin
                    wr_ready_reg <= 1'b1;
                    state_reg    <= PMA_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_rd_data_o = '0;
        for (int i = 0; i < PMA_REGIONS; i++) begin
            if (s_rd_index_i == RW'(i)) begin
                case (s_rd_field_i)
                    PMA_FIELD_BASE: s_rd_data_o = cfg[i].base;
                    PMA_FIELD_MASK: s_rd_data_o = cfg[i].mask;
                    PMA_FIELD_ATTR: s_rd_data_o = pma_attr_word(cfg[i]);
                    default:        s_rd_data_o = '0;
                endcase
            end
        end
    end

    assign s_wr_ready_o  = wr_ready_reg;
    assign s_wr_err_o    = wr_err_reg;
    assign s_scrub_err_o = scrub_err_reg;
    assign s_scrub_cnt_o = scrub_cnt_reg;
    assign s_cfg_o       = cfg;

endmodule

// File: tb/tb_pma_cfg_ctrl.sv
// Self-checking bench for pma_cfg_ctrl: table-driven writes through a scoreboard
// queue, plus hand sequences for scrubbing, saturation, write priority and reset.
module tb_pma_cfg_ctrl;
    import pma_cfg_ctrl_pkg::*;

    localparam pma_cfg_t C0 = '{base: 32'h0000_0000, mask: 32'hF000_0000, lock: 1'b0,
                                idempotent: 1'b1, read_only: 1'b0, executable: 1'b1};
    localparam pma_cfg_t C1 = '{base: 32'h2000_0000, mask: 32'hFF00_0000, lock: 1'b0,
                                idempotent: 1'b0, read_only: 1'b1, executable: 1'b0};
    localparam pma_cfg_t C2 = '{base: 32'h4000_0000, mask: 32'hFFF0_0000, lock: 1'b0,
                                idempotent: 1'b0, read_only: 1'b0, executable: 1'b1};
    localparam pma_cfg_t C3 = '{base: 32'h8000_0400, mask: 32'hFFFF_FC00, lock: 1'b0,
                                idempotent: 1'b1, read_only: 1'b0, executable: 1'b0};
    localparam pma_cfg_t [3:0] TB_CFG = {C3, C2, C1, C0};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [1:0]        wr_index;
    logic [1:0]        wr_field;
    logic [31:0]       wr_data;
    logic              wr_err;
    logic [1:0]        rd_index;
    logic [1:0]        rd_field;
    logic [31:0]       rd_data;
    pma_cfg_t [3:0]    cfg;
    logic [3:0]        lock;
    logic              inj_valid;
    logic [1:0]        inj_index;
    logic              scrub_err;
    logic [7:0]        scrub_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  idx;
        logic [1:0]  field;
        logic [31:0] data;
        logic [1:0]  rd_idx;
        logic [1:0]  rd_field;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];

    pma_cfg_ctrl #(
        .PMA_REGIONS (4),
        .PMA_ALIGN   (10),
        .PMA_CFG     (TB_CFG)
    ) dut (
        .s_clk_i       (clk),
        .s_resetn_i    (rst_n),
        .s_wr_valid_i  (wr_valid),
        .s_wr_ready_o  (wr_ready),
        .s_wr_index_i  (wr_index),
        .s_wr_field_i  (wr_field),
        .s_wr_data_i   (wr_data),
        .s_wr_err_o    (wr_err),
        .s_rd_index_i  (rd_index),
        .s_rd_field_i  (rd_field),
        .s_rd_data_o   (rd_data),
        .s_cfg_o       (cfg),
        .s_lock_o      (lock),
        .s_inj_valid_i (inj_valid),
        .s_inj_index_i (inj_index),
        .s_scrub_err_o (scrub_err),
        .s_scrub_cnt_o (scrub_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Outputs are sampled and inputs driven 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [1:0] field, input logic [31:0] data,
                            output logic err, output logic rdy);
        wr_valid = 1'b1;
        wr_index = idx;
        wr_field = field;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
        err = wr_err;
        rdy = wr_ready;
        tick();
    endtask

    initial begin
        logic  err, rdy;
        vec_t  e;
        int    pulses, timeouts, waited;

        rst_n = 1'b0; wr_valid = 1'b0; wr_index = '0; wr_field = '0; wr_data = '0;
        rd_index = '0; rd_field = '0; inj_valid = 1'b0; inj_index = '0;

        vecs[0] = '{2'd1, 2'd0, 32'h8000_03FF, 2'd1, 2'd0, 1'b0, 32'h8000_0000};
        vecs[1] = '{2'd1, 2'd1, 32'hFFFF_FFFF, 2'd1, 2'd1, 1'b0, 32'hFFFF_FC00};
        vecs[2] = '{2'd0, 2'd2, 32'h0000_007E, 2'd0, 2'd2, 1'b0, 32'h0000_0006};
        vecs[3] = '{2'd2, 2'd2, 32'h0000_0081, 2'd2, 2'd2, 1'b0, 32'h0000_0081};
        vecs[4] = '{2'd2, 2'd0, 32'h1000_0000, 2'd2, 2'd0, 1'b1, 32'h4000_0000};
        vecs[5] = '{2'd2, 2'd2, 32'h0000_0000, 2'd2, 2'd2, 1'b1, 32'h0000_0081};
        vecs[6] = '{2'd3, 2'd3, 32'h1234_5678, 2'd3, 2'd0, 1'b1, 32'h8000_0400};
        vecs[7] = '{2'd0, 2'd0, 32'hFFFF_FFFF, 2'd0, 2'd0, 1'b0, 32'hFFFF_FC00};

        // Reset state
        repeat (3) tick();
        chk("reset_cfg", 300'(cfg), 300'(TB_CFG));
        chk("reset_ready", 300'(wr_ready), 300'(1'b1));
        chk("reset_cnt", 300'(scrub_cnt), 300'(8'd0));
        chk("reset_lock", 300'(lock), 300'(4'b0000));
        rst_n = 1'b1;
        tick();
        rd_index = 2'd3; rd_field = 2'd2; #1;
        chk("reset_rd_attr3", 300'(rd_data), 300'(32'h0000_0004));
        chk("idle_err", 300'(wr_err), 300'(1'b0));
        chk("idle_scrub_err", 300'(scrub_err), 300'(1'b0));

        // Table-driven writes through the scoreboard
        for (int i = 0; i < 8; i++) begin
            sb.push_back(vecs[i]);
            do_write(vecs[i].idx, vecs[i].field, vecs[i].data, err, rdy);
            e = sb.pop_front();
            chk("commit_ready", 300'(rdy), 300'(1'b0));
            chk("wr_err", 300'(err), 300'(e.exp_err));
            chk("err_cleared", 300'(wr_err), 300'(1'b0));
            rd_index = e.rd_idx; rd_field = e.rd_field; #1;
            chk("rd_data", 300'(rd_data), 300'(e.exp_rd));
            $display("WR idx=%0d field=%0d data=%08h err=%0b rd[%0d.%0d]=%08h",
                     e.idx, e.field, e.data, err, e.rd_idx, e.rd_field, rd_data);
        end
        chk("cfg1_base", 300'(cfg[1].base), 300'(32'h8000_0000));
        chk("lock_after_vectors", 300'(lock), 300'(4'b0100));

        // Injection on an idle bus repairs region 1 back to its default
        inj_valid = 1'b1; inj_index = 2'd1;
        tick();
        inj_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (scrub_err) pulses++;
        end
        $display("INJ region=1 pulses=%0d cnt=%0d", pulses, scrub_cnt);
        chk("repair_pulses", 300'(pulses), 300'(1));
        chk("repair_region1", 300'(cfg[1]), 300'(C1));
        chk("repair_cnt", 300'(scrub_cnt), 300'(8'd1));
        chk("repair_keeps_lock2", 300'(lock), 300'(4'b0100));

        // Saturation of the repair counter
        timeouts = 0;
        for (int k = 0; k < 300; k++) begin
            inj_valid = 1'b1; inj_index = 2'd0;
            tick();
            inj_valid = 1'b0;
            waited = 0;
            while (!scrub_err && waited < 12) begin
                tick();
                waited++;
            end
            if (!scrub_err) timeouts++;
        end
        repeat (8) tick();
        $display("INJ x300 region=0 cnt=%0d timeouts=%0d", scrub_cnt, timeouts);
        chk("inj_timeouts", 300'(timeouts), 300'(0));
        chk("cnt_saturated", 300'(scrub_cnt), 300'(8'd255));
        chk("region0_restored", 300'(cfg[0]), 300'(C0));

        // Continuous writes hold off the scrubber
        do_reset();
        wr_valid = 1'b1; wr_index = 2'd0; wr_field = 2'd0; wr_data = 32'h0000_0000;
        inj_valid = 1'b1; inj_index = 2'd1;
        tick();
        inj_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (scrub_err) pulses++;
        end
        chk("no_repair_while_writing", 300'(pulses), 300'(0));
        wr_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (scrub_err) pulses++;
        end
        $display("PRIO writes then idle pulses=%0d cnt=%0d", pulses, scrub_cnt);
        chk("repair_after_valid_drops", 300'(pulses), 300'(1));
        chk("prio_cnt", 300'(scrub_cnt), 300'(8'd1));
        chk("prio_region1", 300'(cfg[1]), 300'(C1));

        // Asynchronous reset in the middle of a COMMIT
        do_reset();
        do_write(2'd2, 2'd2, 32'h0000_0081, err, rdy);
        do_write(2'd3, 2'd0, 32'h1234_5400, err, rdy);
        chk("pre_reset_lock", 300'(lock), 300'(4'b0100));
        chk("pre_reset_base3", 300'(cfg[3].base), 300'(32'h1234_5400));
        wr_valid = 1'b1; wr_index = 2'd0; wr_field = 2'd0; wr_data = 32'hABCD_0000;
        tick();
        wr_valid = 1'b0;
        chk("in_commit_ready", 300'(wr_ready), 300'(1'b0));
        rst_n = 1'b0;
        #1;
        $display("RST during commit cfg0_base=%08h lock=%04b", cfg[0].base, lock);
        chk("async_reset_cfg", 300'(cfg), 300'(TB_CFG));
        chk("async_reset_lock", 300'(lock), 300'(4'b0000));
        chk("async_reset_ready", 300'(wr_ready), 300'(1'b1));
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_reset_cfg", 300'(cfg), 300'(TB_CFG));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pma_cfg_ctrl.md
Name: pma_cfg_ctrl

Overview:
Run-time configuration controller for the physical memory attribute region table that the fetch-side and data-side PMA checkers consume. It holds the active region table (base, mask, attributes, per-region lock) and accepts writes over a valid/ready port, with illegal and locked-region writes rejected. A background scrubber checks per-region parity and restores a corrupted region to its reset default. The block drives the region-table inputs of both PMA checkers in the core.

Parameters:
PMA_REGIONS  4  number of regions in the table
PMA_ALIGN  10  region granularity; base/mask bits [PMA_ALIGN-1:0] are forced to 0
PMA_CFG  '{default:PMA_DEFAULT}  reset/default value of each region, of type pma_cfg_t[PMA_REGIONS-1:0]

Ports:
s_clk_i  in  1  clock
s_resetn_i  in  1  reset, asynchronous, active-low
s_wr_valid_i  in  1  write request
s_wr_ready_o  out  1  write accepted when valid & ready
s_wr_index_i  in  RW=$clog2(PMA_REGIONS) (min 1)  target region
s_wr_field_i  in  2  0 = base, 1 = mask, 2 = attributes, 3 = reserved
s_wr_data_i  in  32  write data; attribute bits: [0] executable, [1] read_only, [2] idempotent, [7] lock
s_wr_err_o  out  1  one-cycle pulse: the write was rejected
s_rd_index_i  in  RW  read region
s_rd_field_i  in  2  read field
s_rd_data_o  out  32  combinational read of the active table; 0 for an invalid index or field 3
s_cfg_o  out  pma_cfg_t[PMA_REGIONS]  active table, driven to the PMA checkers
s_lock_o  out  PMA_REGIONS  per-region lock state
s_inj_valid_i  in  1  fault-injection hook: flip the stored parity bit of region s_inj_index_i
s_inj_index_i  in  RW  region to inject
s_scrub_err_o  out  1  one-cycle pulse: a region was repaired
s_scrub_cnt_o  out  8  saturating count of repairs

Behaviour:
- Reset values: table = PMA_CFG, with lock bits 0 and parity recomputed.
- Reset values: s_wr_ready_o = 1, s_wr_err_o = 0, s_scrub_err_o = 0, s_scrub_cnt_o = 0, scrub pointer = 0, FSM = IDLE.
- FSM states:
  - IDLE: s_wr_ready_o = 1.
    - A handshake captures index, field and data, then goes to COMMIT.
    - With no s_wr_valid_i, the scrubber checks region[ptr] this cycle. On a parity mismatch it goes to REPAIR; otherwise ptr advances.
    - A write request has priority over scrubbing.
  - COMMIT: s_wr_ready_o = 0.
    - Rejected (s_wr_err_o = 1 in this cycle, table unchanged) when: index >= PMA_REGIONS, field = 3, or the target region is locked.
    - Otherwise the field is updated with bits [PMA_ALIGN-1:0] cleared for base/mask and only bits 0..2 and 7 kept for attributes; region parity is recomputed.
    - Always returns to IDLE.
  - REPAIR: s_wr_ready_o = 0.
    - region[ptr] is reloaded from PMA_CFG[ptr] with lock = 0 and parity recomputed.
    - s_scrub_err_o = 1 in this cycle; s_scrub_cnt_o increments and saturates at 255.
    - ptr advances and the FSM returns to IDLE.
- Latency: handshake in cycle N -> COMMIT in N+1 -> new value visible on s_cfg_o and s_rd_data_o from N+2. Back-to-back writes are accepted no more often than every 2 cycles.
- Scrub pointer wraps from PMA_REGIONS-1 to 0. A full sweep takes PMA_REGIONS idle cycles.
- Lock: set by an attribute write with bit 7 = 1 and sticky until reset. The write that sets lock is itself applied.
- Parity: one even-parity bit per region, covering base[31:PMA_ALIGN], mask[31:PMA_ALIGN] and the 4 attribute bits.
- Fault injection: s_inj_valid_i flips the stored parity of the region that same cycle, in any state.
  - If it coincides with a COMMIT/REPAIR to the same region, the injection is applied after the recompute, so the region ends corrupted.
- Reset mid-COMMIT/REPAIR: the asynchronous reset discards the pending operation, and the table returns to PMA_CFG immediately.
- s_cfg_o always reflects the stored table, including a corrupted region until it is repaired.

Decomposition:
- p_hardisc gains:
  - the existing pma_cfg_t, extended with a lock bit;
  - constants PMA_FIELD_BASE/MASK/ATTR and PMA_ATTR_EXEC/RO/IDEM/LOCK bit positions;
  - the FSM enum pma_ctrl_state_t.
- One sub-module, pma_region_reg: a single region's storage plus parity generate/check, instantiated PMA_REGIONS times.

Test Plan:
1. Reset with PMA_REGIONS = 4 -> s_cfg_o == PMA_CFG, s_wr_ready_o = 1, s_scrub_cnt_o = 0.
2. Write region 1 base = 0x8000_03FF -> s_wr_ready_o = 0 in N+1; s_cfg_o[1].base = 0x8000_0000 from N+2; s_wr_err_o stays 0.
3. Write region 2 attributes = 0x81 (exec + lock), then base = 0x1000_0000 -> second write: s_wr_err_o pulses, base unchanged, s_lock_o[2] = 1.
4. Write index 5 or field 3 -> s_wr_err_o pulse, table unchanged.
5. Inject region 3 with the bus idle -> within 4 idle cycles s_scrub_err_o pulses once, region 3 == PMA_CFG[3], s_scrub_cnt_o = 1; 300 injections -> s_scrub_cnt_o = 255.
6. Continuous s_wr_valid_i plus an injection -> no repair while writes are pending; repair occurs within 4 cycles after valid drops. Assert s_resetn_i low during COMMIT -> table = PMA_CFG, locks cleared.
